// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source select, load kinds
// and the low-address masks used to detect misaligned loads.
package wb_pkg;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_LINK = 2'b10,
    SEL_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_WORD   = 3'b000,
    LD_BYTE_S = 3'b001,
    LD_BYTE_U = 3'b010,
    LD_HALF_S = 3'b011,
    LD_HALF_U = 3'b100
  } load_type_e;

  localparam logic [1:0] BYTE_ALIGN_MASK = 2'b00;
  localparam logic [1:0] HALF_ALIGN_MASK = 2'b01;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // Unlisted load kinds behave as word loads, including their alignment rule.
  function automatic logic [1:0] align_mask(input logic [2:0] load_type);
    case (load_type)
      LD_BYTE_S, LD_BYTE_U: return BYTE_ALIGN_MASK;
      LD_HALF_S, LD_HALF_U: return HALF_ALIGN_MASK;
      default:              return WORD_ALIGN_MASK;
    endcase
  endfunction

endpackage

// File: rtl/wb_pipe_stage_if.sv
// MEM-to-WB handshake and register-file write bus of the write-back stage.
interface wb_pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_wb_sel;
  logic [2:0]        in_load_type;
  logic [DATA_W-1:0] in_address;
  logic [DATA_W-1:0] in_read_data;
  logic [DATA_W-1:0] in_link_pc;
  logic              in_reg_write;
  logic [REG_AW-1:0] in_dest_reg;
  logic              rf_busy;
  logic              wb_valid;
  logic              wb_we;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_out;
  logic              align_err;
  logic [31:0]       retire_cnt;

  modport master (
    output in_valid, in_wb_sel, in_load_type, in_address, in_read_data,
           in_link_pc, in_reg_write, in_dest_reg, rf_busy,
    input  in_ready, wb_valid, wb_we, wb_dest, wb_out, align_err, retire_cnt
  );

  modport slave (
    input  in_valid, in_wb_sel, in_load_type, in_address, in_read_data,
           in_link_pc, in_reg_write, in_dest_reg, rf_busy,
    output in_ready, wb_valid, wb_we, wb_dest, wb_out, align_err, retire_cnt
  );

endinterface

// File: rtl/wb_load_ext.sv
// Combinational load formatter: picks the little-endian byte/half/word lane
// addressed by the low address bits and zero- or sign-extends it to DATA_W.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        load_type,
  input  logic [2:0]        addr_lo,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] load_result
);

  logic [31:0] word_lane;
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] v);
    logic signed [DATA_W-1:0] r;
    r = DATA_W'(v);
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] v);
    logic signed [DATA_W-1:0] r;
    r = DATA_W'(v);
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext32(input logic signed [31:0] v);
    logic signed [DATA_W-1:0] r;
    r = DATA_W'(v);
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] zext8(input logic [7:0] v);
    return DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    return DATA_W'(v);
  endfunction

  // On a 64-bit datapath address bit 2 picks the 32-bit word holding the lane.
  generate
    if (DATA_W == 64) begin : g_w64
      assign word_lane = addr_lo[2] ? read_data[63:32] : read_data[31:0];
    end else begin : g_w32
      logic unused_addr2;
      assign unused_addr2 = addr_lo[2];
      assign word_lane    = read_data[31:0];
    end
  endgenerate

  always_comb begin
    byte_lane   = word_lane[7:0];
    half_lane   = word_lane[15:0];
    load_result = sext32(word_lane);

    case (addr_lo[1:0])
      2'd1:    byte_lane = word_lane[15:8];
      2'd2:    byte_lane = word_lane[23:16];
      2'd3:    byte_lane = word_lane[31:24];
      default: byte_lane = word_lane[7:0];
    endcase

    if (addr_lo[1]) begin
      half_lane = word_lane[31:16];
    end

    case (load_type)
      LD_BYTE_S: load_result = sext8(byte_lane);
      LD_BYTE_U: load_result = zext8(byte_lane);
      LD_HALF_S: load_result = sext16(half_lane);
      LD_HALF_U: load_result = zext16(half_lane);
      default:   load_result = sext32(word_lane);
    endcase
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// Write-back pipeline stage: one-entry register between MEM and the register
// file with valid/ready handshake, misaligned-load suppression and retire count.
module wb_pipe_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic             clk,
  input logic             rst_n,
  wb_pipe_stage_if.slave  bus
);

  logic              accept;
  logic              retire;
  logic              mis_in;
  logic              we_in;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] wb_data;

  logic              vld_p0;
  logic              we_p0;
  logic              mis_p0;
  logic [REG_AW-1:0] dest_p0;
  logic [DATA_W-1:0] out_p0;
  logic [31:0]       cnt_p0;
  logic              align_err_p1;

  assign bus.in_ready = !vld_p0 || !bus.rf_busy;
  assign accept       = bus.in_valid && bus.in_ready;
  assign retire       = vld_p0 && !bus.rf_busy;

  wb_load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .load_type   (bus.in_load_type),
    .addr_lo     (bus.in_address[2:0]),
    .read_data   (bus.in_read_data),
    .load_result (load_val)
  );

  // Reserved select falls through to the ALU result.
  always_comb begin
    wb_data = bus.in_address;
    case (bus.in_wb_sel)
      SEL_MEM:  wb_data = load_val;
      SEL_LINK: wb_data = bus.in_link_pc;
      default:  wb_data = bus.in_address;
    endcase
  end

  assign mis_in = (bus.in_wb_sel == SEL_MEM) &&
                  ((bus.in_address[1:0] & align_mask(bus.in_load_type)) != 2'b00);
  assign we_in  = bus.in_reg_write && (bus.in_dest_reg != '0) && !mis_in;

  // ---- MEM -> WB register (p0); align_err is one stage later (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0       <= 1'b0;
      we_p0        <= 1'b0;
      mis_p0       <= 1'b0;
      dest_p0      <= '0;
      out_p0       <= '0;
      cnt_p0       <= '0;
      align_err_p1 <= 1'b0;
    end else begin
      if (accept) begin
        vld_p0  <= 1'b1;
        we_p0   <= we_in;
        mis_p0  <= mis_in;
        dest_p0 <= bus.in_dest_reg;
        out_p0  <= wb_data;
      end else if (retire) begin
        vld_p0 <= 1'b0;
        we_p0  <= 1'b0;
        mis_p0 <= 1'b0;
      end

      align_err_p1 <= retire && mis_p0;

      if (retire) begin
        cnt_p0 <= cnt_p0 + 32'd1;
      end
    end
  end

  assign bus.wb_valid   = vld_p0;
  assign bus.wb_we      = we_p0;
  assign bus.wb_dest    = dest_p0;
  assign bus.wb_out     = out_p0;
  assign bus.align_err  = align_err_p1;
  assign bus.retire_cnt = cnt_p0;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_wb_pipe_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  wb_pipe_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  wb_pipe_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] out;
    logic [4:0]  dest;
    logic        we;
    logic        mis;
  } ent_t;

  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  ent_t        m_q[$];
  logic [31:0] m_cnt = '0;
  logic        m_align = 1'b0;
  bit          m_busy, m_rdy, m_ret, m_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected write-back entry derived directly from the select/load rules.
  function automatic ent_t model_entry(input logic [1:0] sel, input logic [2:0] lt,
                                       input logic [31:0] a, input logic [31:0] rd,
                                       input logic [31:0] lk, input logic rw,
                                       input logic [4:0] d);
    ent_t e;
    logic [31:0] b, h, memv;
    b = (rd >> (8 * a[1:0])) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    case (lt)
      3'd1:    memv = (b >= 32'd128)   ? b - 32'd256   : b;
      3'd2:    memv = b;
      3'd3:    memv = (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    memv = h;
      default: memv = rd;
    endcase
    e.mis  = (sel == 2'd1) &&
             ((((lt == 3'd3) || (lt == 3'd4)) && (a % 2 != 0)) ||
              ((lt == 3'd0 || lt > 3'd4) && (a % 4 != 0)));
    e.out  = (sel == 2'd1) ? memv : (sel == 2'd2) ? lk : a;
    e.dest = d;
    e.we   = rw && (d != 5'd0) && !e.mis;
    return e;
  endfunction

  // Reference model: queue of accepted instructions, head is what WB shows.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_cnt   = '0;
      m_align = 1'b0;
    end else begin
      m_busy  = bus.rf_busy;
      m_rdy   = (m_q.size() == 0) || !m_busy;
      m_ret   = (m_q.size() != 0) && !m_busy;
      m_acc   = bus.in_valid && m_rdy;
      m_align = m_ret ? m_q[0].mis : 1'b0;
      if (m_ret) begin
        void'(m_q.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (m_acc) begin
        m_q.push_back(model_entry(bus.in_wb_sel, bus.in_load_type, bus.in_address,
                                  bus.in_read_data, bus.in_link_pc, bus.in_reg_write,
                                  bus.in_dest_reg));
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", bus.in_ready, (m_q.size() == 0) || !bus.rf_busy);
      chk("wb_valid", bus.wb_valid, m_q.size() != 0);
      chk("retire_cnt", bus.retire_cnt, m_cnt);
      chk("align_err", bus.align_err, m_align);
      if (m_q.size() != 0) begin
        chk("wb_out", bus.wb_out, m_q[0].out);
        chk("wb_dest", bus.wb_dest, m_q[0].dest);
        chk("wb_we", bus.wb_we, m_q[0].we);
      end else begin
        chk("wb_we_idle", bus.wb_we, 1'b0);
      end
    end
  end

  task automatic set_in(input logic v, input logic [1:0] sel, input logic [2:0] lt,
                        input logic [31:0] a, input logic [31:0] rd, input logic [31:0] lk,
                        input logic rw, input logic [4:0] d, input logic busy);
    bus.in_valid     = v;
    bus.in_wb_sel    = sel;
    bus.in_load_type = lt;
    bus.in_address   = a;
    bus.in_read_data = rd;
    bus.in_link_pc   = lk;
    bus.in_reg_write = rw;
    bus.in_dest_reg  = d;
    bus.rf_busy      = busy;
  endtask

  task automatic idle(input logic busy);
    set_in(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, busy);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle(1'b0);
    #1 rst_n = 1'b0;
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_wb_valid", bus.wb_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_retire_cnt", bus.retire_cnt, 32'h0);
    chk("rst_wb_out", bus.wb_out, 32'h0);
    rst_n = 1'b1;

    // Signed byte load from lane 1
    set_in(1'b1, 2'd1, 3'd1, 32'h0000_1001, 32'h1234_80FF, 32'h0, 1'b1, 5'd3, 1'b0);
    step();
    chk("lb_out", bus.wb_out, 32'hFFFF_FF80);
    chk("lb_we", bus.wb_we, 1'b1);
    chk("lb_dest", bus.wb_dest, 5'd3);

    // Unsigned half load from upper half
    set_in(1'b1, 2'd1, 3'd4, 32'h0000_1002, 32'h8001_0000, 32'h0, 1'b1, 5'd5, 1'b0);
    step();
    chk("lhu_out", bus.wb_out, 32'h0000_8001);
    chk("lhu_we", bus.wb_we, 1'b1);
    chk("lhu_cnt", bus.retire_cnt, 32'd1);

    // Misaligned half load
    set_in(1'b1, 2'd1, 3'd3, 32'h0000_1003, 32'h8001_0000, 32'h0, 1'b1, 5'd6, 1'b0);
    step();
    chk("mis_we", bus.wb_we, 1'b0);
    chk("mis_valid", bus.wb_valid, 1'b1);
    chk("mis_align_pre", bus.align_err, 1'b0);
    idle(1'b0);
    step();
    chk("mis_align_pulse", bus.align_err, 1'b1);
    chk("mis_cnt", bus.retire_cnt, 32'd3);
    step();
    chk("mis_align_end", bus.align_err, 1'b0);

    // Link select, then the same with dest 0
    set_in(1'b1, 2'd2, 3'd0, 32'h0000_0123, 32'h0, 32'h0040_0008, 1'b1, 5'd31, 1'b0);
    step();
    chk("link_out", bus.wb_out, 32'h0040_0008);
    chk("link_we", bus.wb_we, 1'b1);
    set_in(1'b1, 2'd2, 3'd0, 32'h0000_0123, 32'h0, 32'h0040_0008, 1'b1, 5'd0, 1'b0);
    step();
    chk("link0_we", bus.wb_we, 1'b0);
    chk("link0_cnt", bus.retire_cnt, 32'd4);
    idle(1'b0);
    step();
    chk("link0_retired_cnt", bus.retire_cnt, 32'd5);

    // Back-to-back with a one-cycle register-file stall
    set_in(1'b1, 2'd0, 3'd0, 32'h100, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0);
    step();
    set_in(1'b1, 2'd0, 3'd0, 32'h200, 32'h0, 32'h0, 1'b1, 5'd2, 1'b1);
    #1 chk("stall_ready", bus.in_ready, 1'b0);
    step();
    chk("stall_hold_out", bus.wb_out, 32'h100);
    chk("stall_hold_dest", bus.wb_dest, 5'd1);
    chk("stall_hold_cnt", bus.retire_cnt, 32'd5);
    set_in(1'b1, 2'd0, 3'd0, 32'h200, 32'h0, 32'h0, 1'b1, 5'd2, 1'b0);
    #1 chk("unstall_ready", bus.in_ready, 1'b1);
    step();
    chk("b2b_b_out", bus.wb_out, 32'h200);
    set_in(1'b1, 2'd0, 3'd0, 32'h300, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0);
    step();
    set_in(1'b1, 2'd0, 3'd0, 32'h400, 32'h0, 32'h0, 1'b1, 5'd4, 1'b0);
    step();
    chk("b2b_d_out", bus.wb_out, 32'h400);
    idle(1'b0);
    step();
    chk("b2b_cnt", bus.retire_cnt, 32'd9);
    chk("b2b_drained", bus.wb_valid, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 3));
      step();
    end
    idle(1'b0);
    step();

    // Asynchronous reset while an instruction is held and stalled
    set_in(1'b1, 2'd0, 3'd0, 32'hABC, 32'h0, 32'h0, 1'b1, 5'd7, 1'b0);
    step();
    idle(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.wb_valid, 1'b0);
    chk("arst_we", bus.wb_we, 1'b0);
    chk("arst_dest", bus.wb_dest, 5'd0);
    chk("arst_out", bus.wb_out, 32'h0);
    chk("arst_cnt", bus.retire_cnt, 32'h0);
    chk("arst_ready", bus.in_ready, 1'b1);
    step();
    rst_n = 1'b1;
    idle(1'b0);
    step();
    chk("arst_after_cnt", bus.retire_cnt, 32'h0);
    chk("arst_after_valid", bus.wb_valid, 1'b0);

    // Counter wrap from a preloaded value
    force dut.cnt_p0 = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1 release dut.cnt_p0;
    set_in(1'b1, 2'd0, 3'd0, 32'h10, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0);
    step();
    chk("wrap_pre", bus.retire_cnt, 32'hFFFF_FFFE);
    set_in(1'b1, 2'd0, 3'd0, 32'h20, 32'h0, 32'h0, 1'b1, 5'd2, 1'b0);
    step();
    chk("wrap_max", bus.retire_cnt, 32'hFFFF_FFFF);
    idle(1'b0);
    step();
    chk("wrap_zero", bus.retire_cnt, 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
